// File: rtl/frame_streamer.sv
// Snapshots the flat board frame and streams it row-major as valid/ready pixel beats.
// Optional XOR checksum of transferred pixels under FRAME_STREAMER_CHECKSUM_EN.
module frame_streamer #(
  parameter int SCR_W = 30,
  parameter int SCR_H = 30,
  parameter int PIX_W = 24,
  parameter int XW    = $clog2(SCR_W),
  parameter int YW    = $clog2(SCR_H)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SCR_W*SCR_H*PIX_W-1:0] screen_in,
  input  logic                         frame_req,
  output logic                         busy,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [PIX_W-1:0]             pix_data,
  output logic [XW-1:0]                pix_x,
  output logic [YW-1:0]                pix_y,
  output logic                         pix_eol,
  output logic                         pix_eof,
  output logic                         frame_done
`ifdef FRAME_STREAMER_CHECKSUM_EN
  ,
  output logic [PIX_W-1:0]             checksum
`endif
);

  localparam int NPIX = SCR_W * SCR_H;
  localparam int IW   = $clog2(NPIX);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} stateT;

  stateT            stateReg, stateNext;
  logic             pendingReg, pendingNext;
  logic [XW-1:0]    xReg;
  logic [YW-1:0]    yReg;
  logic             capture;
  logic             xfer;
  logic             lastX, lastY;
  logic [IW-1:0]    wordIdx;
  logic [PIX_W-1:0] screenWords [NPIX];
  logic [PIX_W-1:0] shadowMem   [NPIX];

  generate
    for (genvar gi = 0; gi < NPIX; gi++) begin : gUnpack
      assign screenWords[gi] = screen_in[gi*PIX_W +: PIX_W];
    end
  endgenerate

  // Whole-frame snapshot in one cycle, so the shadow is a register bank, not RAM.
  always_ff @(posedge clk) begin
    if (capture) begin
      shadowMem <= screenWords;
    end
  end

  assign lastX   = (xReg == XW'(SCR_W - 1));
  assign lastY   = (yReg == YW'(SCR_H - 1));
  assign xfer    = (stateReg == STREAM) && pix_ready;
  assign wordIdx = IW'(xReg) * IW'(SCR_H) + IW'(yReg);

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      pendingReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      pendingReg <= pendingNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    pendingNext = pendingReg;
    capture     = 1'b0;
    case (stateReg)
      IDLE: begin
        if (frame_req) begin
          capture   = 1'b1;
          stateNext = STREAM;
        end
      end
      STREAM: begin
        if (frame_req) pendingNext = 1'b1;
        if (pix_ready && lastX && lastY) stateNext = DONE;
      end
      DONE: begin
        // A request arriving in this very cycle is honoured like a pending one.
        pendingNext = 1'b0;
        if (pendingReg || frame_req) begin
          capture   = 1'b1;
          stateNext = STREAM;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || capture) begin
      xReg <= '0;
      yReg <= '0;
    end else if (xfer) begin
      if (lastX) begin
        xReg <= '0;
        yReg <= lastY ? '0 : yReg + 1'b1;
      end else begin
        xReg <= xReg + 1'b1;
      end
    end
  end

  assign pix_valid  = (stateReg == STREAM);
  assign busy       = (stateReg != IDLE);
  assign frame_done = (stateReg == DONE);
  assign pix_x      = xReg;
  assign pix_y      = yReg;
  assign pix_eol    = pix_valid && lastX;
  assign pix_eof    = pix_valid && lastX && lastY;
  assign pix_data   = pix_valid ? shadowMem[wordIdx] : '0;

`ifdef FRAME_STREAMER_CHECKSUM_EN
  logic [PIX_W-1:0] checksumReg;

  always_ff @(posedge clk) begin
    if (reset || capture) begin
      checksumReg <= '0;
    end else if (xfer) begin
      checksumReg <= checksumReg ^ pix_data;
    end
  end

  assign checksum = checksumReg;
`endif

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Downstream consumer of the game board's flat `screen` output.
- On request, snapshots the whole SCR_W x SCR_H RGB frame into a shadow buffer.
- Streams the frame as a row-major raster of 24-bit pixels over a valid/ready interface, with coordinates and end-of-line/end-of-frame markers, toward display/scan-out logic.
- The snapshot decouples the stream from the board updating `screen` mid-transfer.

Parameters:
- SCR_W, 30, screen width in pixels.
- SCR_H, 30, screen height in pixels.
- PIX_W, 24, pixel word width ({r[7:0], g[7:0], b[7:0]}).
- XW, $clog2(SCR_W), width of pix_x.
- YW, $clog2(SCR_H), width of pix_y.

Ports:
- clk  input  1  clock.
- reset  input  1  reset; synchronous, active-high.
- screen_in  input  SCR_W*SCR_H*PIX_W  flat frame; pixel (x,y) at word index x*SCR_H+y, word k occupies bits [k*PIX_W +: PIX_W].
- frame_req  input  1  single-cycle request to capture and stream one frame.
- busy  output  1  high from capture cycle+1 until the frame_done cycle inclusive.
- pix_valid  output  1  pixel beat valid.
- pix_ready  input  1  sink accepts beat.
- pix_data  output  PIX_W  pixel word.
- pix_x  output  XW  column of current beat.
- pix_y  output  YW  row of current beat.
- pix_eol  output  1  beat is last of a row (pix_x==SCR_W-1).
- pix_eof  output  1  beat is last of the frame (eol and pix_y==SCR_H-1).
- frame_done  output  1  one-cycle pulse after the eof beat is accepted.

Behaviour:
- Reset values: busy=0, pix_valid=0, pix_data=0, pix_x=0, pix_y=0, pix_eol=0, pix_eof=0, frame_done=0. State=IDLE, pending flag cleared.
- Reset mid-frame aborts immediately. Next cycle pix_valid=0 and the shadow contents are don't-care.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - On frame_req=1, the shadow buffer captures screen_in in that cycle; next state STREAM.
  - Latency: first beat valid exactly 1 cycle after frame_req.
- STREAM:
  - pix_valid=1; raster order y outer 0..SCR_H-1, x inner 0..SCR_W-1.
  - pix_data = shadow word[x*SCR_H+y].
  - A transfer occurs when pix_valid && pix_ready. x increments, wrapping to 0 at SCR_W-1 with y incrementing.
  - While pix_valid && !pix_ready, pix_data/pix_x/pix_y/pix_eol/pix_eof hold stable.
  - On transfer of the eof beat, next state DONE.
  - Maximum throughput is 1 beat/cycle with no bubbles between rows.
- DONE (one cycle):
  - frame_done=1, pix_valid=0, busy=1.
  - If pending=1, capture screen_in this cycle, clear pending, next state STREAM (first beat next cycle). Otherwise next state IDLE.
- frame_req in STREAM or DONE sets pending; multiple requests collapse to one.
- frame_req in DONE while pending=0 is treated as pending, so capture happens in that same DONE cycle.
- screen_in changes after capture never affect the stream in progress.
- Counters saturate only via the FSM; x/y are reset to 0 on every capture.

Optional Feature:
- Macro FRAME_STREAMER_CHECKSUM_EN.
- Defined:
  - Adds output `checksum` (PIX_W bits), the XOR of all pix_data words transferred in the frame.
  - Accumulator clears on capture.
  - `checksum` is valid and held from the frame_done cycle until the next capture; reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: assert reset 2 cycles with frame_req=1 -> all outputs 0, no stream starts; after release with frame_req=0, pix_valid stays 0.
- Full frame, pix_ready=1, screen_in word(x,y)={8'(x),8'(y),8'h5A}, frame_req at cycle 0:
  - beat 1 at cycle 1 has x=0,y=0,data=0x00005A.
  - Beat 30 has eol=1, data=0x1D005A.
  - Beat 900 at cycle 900 has eof=1, data=0x1D1D5A.
  - frame_done at cycle 901; busy=0 at cycle 902.
- Backpressure: drop pix_ready for 5 cycles while beat x=1,y=1 (data 0x01015A) is presented -> outputs held identical for 5 cycles; next accepted beat is x=2,y=1; total beat count 900, no duplicates or gaps.
- Snapshot isolation: after frame_req, set every screen_in word to 0xFFFFFF -> all 900 streamed words still match the original pattern.
- Back-to-back: pulse frame_req twice at beat 200 of frame 1 -> exactly one additional frame; its capture occurs in the frame_done cycle and its first beat one cycle later; busy stays 1 across both frames.
- Abort: assert reset at beat 100 -> next cycle pix_valid=0, busy=0; pending dropped; a later frame_req streams from x=0,y=0. With FRAME_STREAMER_CHECKSUM_EN and the pattern frame, checksum equals the XOR computed by the bench over all 900 words.
